// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller.
// Size masks follow the decoder's mem_wrnum encoding.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

   localparam logic [3:0] MW_BYTE = 4'b0001;
   localparam logic [3:0] MW_HALF = 4'b0011;
   localparam logic [3:0] MW_WORD = 4'b1111;

   function automatic logic legal_mask(input logic [3:0] wrnum);
      return (wrnum == MW_BYTE) || (wrnum == MW_HALF) || (wrnum == MW_WORD);
   endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load data alignment: pulls the addressed bytes down to bit 0 and
// sign- or zero-extends byte/half results. Bytes shifted past lane 3 read as 0.
module lsu_ld_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [3:0]  wrnum,
   input  logic        us,
   output logic [31:0] ld_data
);

   logic [31:0] w;

   always_comb begin
      w       = rdata >> {off, 3'b000};
      ld_data = w;
      case (wrnum)
         MW_BYTE: ld_data = {{24{~us & w[7]}},  w[7:0]};
         MW_HALF: ld_data = {{16{~us & w[15]}}, w[15:0]};
         default: ld_data = w;
      endcase
   end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Single-cycle core LSU: turns one load/store into a valid/ready bus transaction
// and stalls the core until it completes. Optional macro: LSU_MISALIGN_CHK_EN.
module lsu_bus_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 256
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        mem_wren,
   input  logic [3:0]  mem_wrnum,
   input  logic        mem_us,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        bus_err,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic        misalign
);

   lsu_state_t  state, state_nxt;
   logic [15:0] cnt;
   logic [1:0]  off;
   logic [3:0]  wrnum_q;
   logic        us_q;
   logic        ok_q, err_q, mis_q;
   logic        legal, bad_align, timeout;
   logic [31:0] ld_word;

   assign legal   = legal_mask(mem_wrnum);
   assign timeout = (cnt == 16'(TIMEOUT_CYC - 1));

`ifdef LSU_MISALIGN_CHK_EN
   assign bad_align = ((mem_wrnum == MW_HALF) && addr[0]) ||
                      ((mem_wrnum == MW_WORD) && (addr[1:0] != 2'b00));
`else
   assign bad_align = 1'b0;
`endif

   lsu_ld_align u_align (
      .rdata   (bus_rdata),
      .off     (off),
      .wrnum   (wrnum_q),
      .us      (us_q),
      .ld_data (ld_word)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req) state_nxt = (legal && !bad_align) ? REQ : DONE;
         // handshake takes priority over an expiring timeout
         REQ:  if (bus_ready) state_nxt = bus_we ? DONE : RESP;
               else if (timeout) state_nxt = DONE;
         RESP: if (bus_rvalid || timeout) state_nxt = DONE;
         DONE: state_nxt = IDLE;
      endcase
   end

   assign stall     = (req && state == IDLE) || state == REQ || state == RESP;
   assign bus_valid = (state == REQ);
   assign ld_valid  = (state == DONE) && ok_q;
   assign bus_err   = (state == DONE) && err_q;
   assign misalign  = (state == DONE) && mis_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         off       <= '0;
         wrnum_q   <= '0;
         us_q      <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         mis_q     <= 1'b0;
         ld_data   <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= (state == REQ || state == RESP) ? cnt + 16'd1 : '0;
         case (state)
            IDLE: if (req) begin
               off     <= addr[1:0];
               wrnum_q <= mem_wrnum;
               us_q    <= mem_us;
               ok_q    <= 1'b0;
               err_q   <= 1'b0;
               mis_q   <= bad_align;
               if (bad_align) ld_data <= '0;
               if (legal && !bad_align) begin
                  bus_we    <= mem_wren;
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_be    <= mem_wrnum << addr[1:0];
                  bus_wdata <= st_data << {addr[1:0], 3'b000};
               end
            end
            REQ: if (!bus_ready && timeout) begin
               err_q   <= 1'b1;
               ld_data <= '0;
            end
            RESP: if (bus_rvalid) begin
               ok_q    <= 1'b1;
               ld_data <= ld_word;
            end else if (timeout) begin
               err_q   <= 1'b1;
               ld_data <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: byte-lane model checked every cycle plus
// literal expectations per transaction (latency, lanes, extension, timeout, reset).
module tb_lsu_bus_ctrl;
   import lsu_pkg::*;

   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, mem_wren = 1'b0, mem_us = 1'b0;
   logic [3:0]  mem_wrnum = '0;
   logic [31:0] addr = '0, st_data = '0;
   logic        stall, ld_valid, bus_err, bus_valid, bus_we, misalign;
   logic [31:0] ld_data, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;

   int checks = 0, failures = 0;

   // slave knobs and current-transaction context for the model
   int          rdy_dly = 0;
   bit          never_ready = 0, no_rvalid = 0, extra_rvalid = 0;
   logic [31:0] m_addr = '0, m_st = '0;
   logic [3:0]  m_wrnum = '0;
   logic        m_we = 1'b0, m_us = 1'b0;

   // per-transaction observations
   int          r_stall, r_vld, r_done, r_ldv, r_err, r_mis;
   logic [31:0] r_ld, r_wd;
   logic [3:0]  r_be;

   always #5 clk = ~clk;

   lsu_bus_ctrl #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .req(req), .mem_wren(mem_wren), .mem_wrnum(mem_wrnum),
      .mem_us(mem_us), .addr(addr), .st_data(st_data), .stall(stall),
      .ld_valid(ld_valid), .ld_data(ld_data), .bus_err(bus_err), .bus_valid(bus_valid),
      .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .misalign(misalign)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int size_of(input logic [3:0] w);
      case (w)
         MW_BYTE: return 1;
         MW_HALF: return 2;
         MW_WORD: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [3:0] w, input logic [31:0] a);
      int o = int'(a[1:0]);
      logic [3:0] be = '0;
      for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i - o < size_of(w));
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] st, input logic [31:0] a);
      int o = int'(a[1:0]);
      logic [31:0] d = '0;
      for (int i = 0; i < 4; i++) if (i >= o) d[8*i +: 8] = st[8*(i-o) +: 8];
      return d;
   endfunction

   function automatic logic [31:0] m_ld(input logic [31:0] rd, input logic [31:0] a,
                                       input logic [3:0] w, input logic us);
      int o = int'(a[1:0]);
      int n = size_of(w);
      logic [31:0] v = '0;
      for (int k = 0; k < n; k++) if (o + k <= 3) v[8*k +: 8] = rd[8*(o+k) +: 8];
      if (!us && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      return v;
   endfunction

   // bus slave: ready after rdy_dly valid cycles, rvalid the cycle after a load handshake
   initial begin
      int vcnt = 0;
      bit arm  = 0;
      forever begin
         @(negedge clk);
         bus_rvalid = (arm && !no_rvalid) || extra_rvalid;
         if (bus_valid) begin
            bus_ready = !never_ready && (vcnt == rdy_dly);
            vcnt++;
         end else begin
            bus_ready = 1'b0;
            vcnt = 0;
         end
         arm = bus_valid && bus_ready && !bus_we && !rst;
      end
   end

   // model comparison on every cycle the bus request or load result is meaningful
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus_valid) begin
            chk("m_bus_addr", bus_addr, {m_addr[31:2], 2'b00});
            chk("m_bus_be", {28'd0, bus_be}, {28'd0, m_be(m_wrnum, m_addr)});
            chk("m_bus_we", {31'd0, bus_we}, {31'd0, m_we});
            if (m_we) chk("m_bus_wdata", bus_wdata, m_wdata(m_st, m_addr));
         end
         if (!rst && ld_valid)
            chk("m_ld_data", ld_data, m_ld(bus_rdata, m_addr, m_wrnum, m_us));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic sample();
      if (stall) r_stall++;
      if (bus_valid) begin r_vld++; r_be = bus_be; r_wd = bus_wdata; end
      if (ld_valid) r_ldv++;
      if (bus_err)  r_err++;
      if (misalign) r_mis++;
   endtask

   task automatic txn(input logic we, input logic [3:0] wr, input logic us,
                      input logic [31:0] a, input logic [31:0] st, input logic [31:0] rd,
                      input int dly, input bit nrdy);
      int c = 1;
      @(negedge clk);
      m_we = we; m_wrnum = wr; m_us = us; m_addr = a; m_st = st;
      bus_rdata = rd; rdy_dly = dly; never_ready = nrdy;
      mem_wren = we; mem_wrnum = wr; mem_us = us; addr = a; st_data = st; req = 1'b1;
      r_stall = 0; r_vld = 0; r_done = 0; r_ldv = 0; r_err = 0; r_mis = 0;
      r_ld = 'x; r_be = '0; r_wd = '0;
      #1;
      forever begin
         sample();
         if (!stall) begin r_done = c; r_ld = ld_data; break; end
         if (c >= 200) begin
            failures++; checks++;
            $display("FAIL txn_bound: got %0d cycles expected completion", c);
            break;
         end
         @(negedge clk); c++;
      end
      req = 1'b0;
      // the cycle after DONE must carry no further pulse
      @(negedge clk); #1;
      if (ld_valid) r_ldv++;
      if (bus_err)  r_err++;
      if (misalign) r_mis++;
   endtask

   initial begin
      int cnt_l;
      repeat (3) @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst_pulses", {29'd0, ld_valid, bus_err, misalign}, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_bus_regs", bus_addr | bus_wdata | {28'd0, bus_be} | {31'd0, bus_we}, 32'd0);
      rst = 1'b0;

      // LW zero-wait
      txn(1'b0, MW_WORD, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0);
      chk("lw_stall", r_stall, 3);
      chk("lw_done_cyc", r_done, 4);
      chk("lw_ldv", r_ldv, 1);
      chk("lw_ld", r_ld, 32'hDEADBEEF);
      chk("lw_be", {28'd0, r_be}, 32'hF);

      // LB sign / zero extension
      txn(1'b0, MW_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0);
      chk("lb_be", {28'd0, r_be}, 32'h8);
      chk("lb_s_ld", r_ld, 32'hFFFFFF80);
      txn(1'b0, MW_BYTE, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0);
      chk("lbu_ld", r_ld, 32'h00000080);

      // SH with slow ready
      txn(1'b1, MW_HALF, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 5, 0);
      chk("sh_vld_cyc", r_vld, 6);
      chk("sh_be", {28'd0, r_be}, 32'hC);
      chk("sh_wdata", r_wd, 32'hABCD0000);
      chk("sh_stall", r_stall, 7);
      chk("sh_done_cyc", r_done, 8);
      chk("sh_ldv", r_ldv, 0);

      // LH sign extension from upper half, SB in lane 1
      txn(1'b0, MW_HALF, 1'b0, 32'h106, 32'h0, 32'h80017FFF, 1, 0);
      chk("lh_ld", r_ld, 32'hFFFF8001);
      txn(1'b1, MW_BYTE, 1'b0, 32'h101, 32'h000000A5, 32'h0, 0, 0);
      chk("sb_be", {28'd0, r_be}, 32'h2);
      chk("sb_wdata", r_wd, 32'h0000A500);
      chk("sb_done_cyc", r_done, 3);

      // timeout: ready never comes
      txn(1'b0, MW_WORD, 1'b0, 32'h300, 32'h0, 32'h55555555, 0, 1);
      chk("to_err", r_err, 1);
      chk("to_done_cyc", r_done, 10);
      chk("to_vld_cyc", r_vld, 8);
      chk("to_ldv", r_ldv, 0);
      chk("to_ld", r_ld, 32'h0);

      // next request after timeout
      txn(1'b1, MW_WORD, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 0, 0);
      chk("post_to_done", r_done, 3);
      chk("post_to_wdata", r_wd, 32'hCAFEF00D);
      chk("post_to_err", r_err, 0);

      // illegal size mask: no bus traffic
      txn(1'b1, 4'b0101, 1'b0, 32'h500, 32'h12345678, 32'h0, 0, 0);
      chk("ill_vld", r_vld, 0);
      chk("ill_done_cyc", r_done, 2);
      chk("ill_stall", r_stall, 1);

      // misaligned word
      txn(1'b0, MW_WORD, 1'b0, 32'h102, 32'h0, 32'hDEADBEEF, 0, 0);
`ifdef LSU_MISALIGN_CHK_EN
      chk("mis_vld", r_vld, 0);
      chk("mis_pulse", r_mis, 1);
      chk("mis_done_cyc", r_done, 2);
      chk("mis_ldv", r_ldv, 0);
      chk("mis_ld", r_ld, 32'h0);
`else
      chk("mis_pulse", r_mis, 0);
      chk("mis_be", {28'd0, r_be}, 32'hC);
      chk("mis_ld", r_ld, 32'h0000DEAD);
      chk("mis_done_cyc", r_done, 4);
`endif

      // reset while waiting for read data
      @(negedge clk);
      no_rvalid = 1;
      m_we = 1'b0; m_wrnum = MW_WORD; m_us = 1'b0; m_addr = 32'h600; rdy_dly = 0; never_ready = 0;
      bus_rdata = 32'h11223344;
      mem_wren = 1'b0; mem_wrnum = MW_WORD; mem_us = 1'b0; addr = 32'h600; req = 1'b1;
      @(negedge clk);
      @(negedge clk); #1;
      chk("rr_resp_stall", {31'd0, stall}, 32'd1);
      chk("rr_resp_valid", {31'd0, bus_valid}, 32'd0);
      rst = 1'b1; req = 1'b0;
      @(negedge clk); #1;
      chk("rr_stall", {31'd0, stall}, 32'd0);
      chk("rr_bus_valid", {31'd0, bus_valid}, 32'd0);
      rst = 1'b0;
      extra_rvalid = 1;
      cnt_l = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (i == 1) extra_rvalid = 0;
         if (ld_valid || bus_err || misalign || stall) cnt_l++;
      end
      chk("rr_late_rvalid", cnt_l, 0);
      no_rvalid = 0;

      txn(1'b0, MW_WORD, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0, 0);
      chk("rr_after_done", r_done, 4);
      chk("rr_after_ld", r_ld, 32'h0BADF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
